// File: rtl/knn_pkg.sv
// Shared types and defaults for the k-NN training-sample feeder.
package knn_pkg;

  localparam int KNN_M            = 2;
  localparam int KNN_N            = 3;
  localparam int KNN_W            = 16;
  localparam int KNN_MAX_ELEMENTS = 32;
  localparam int KNN_TYPE_W       = 3;
  localparam int KNN_SAMPLE_W     = KNN_W * KNN_M * KNN_N;
  localparam int KNN_AW           = $clog2(KNN_MAX_ELEMENTS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_READ    = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

  // A pass needs at least one sample and cannot exceed the memory depth.
  function automatic logic num_in_range(input logic [31:0] n, input logic [31:0] max_n);
    return (n != 32'd0) && (n <= max_n);
  endfunction

endpackage

// File: rtl/knn_sample_ram.sv
// Single-port-read / single-port-write synchronous sample memory, read-first on collision.
module knn_sample_ram
  import knn_pkg::*;
#(
  parameter int DEPTH = KNN_MAX_ELEMENTS,
  parameter int WIDTH = KNN_SAMPLE_W + KNN_TYPE_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Storage and registered read; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/knn_training_feeder.sv
// Serves stored training samples, one per data_request, to the distance calculator.
// Optional build macro KNN_FEEDER_WRAP_EN: passes repeat continuously instead of ending in IDLE.
module knn_training_feeder
  import knn_pkg::*;
#(
  parameter int M            = KNN_M,
  parameter int N            = KNN_N,
  parameter int W            = KNN_W,
  parameter int MAX_ELEMENTS = KNN_MAX_ELEMENTS,
  parameter int TYPE_W       = KNN_TYPE_W,
  localparam int AW          = $clog2(MAX_ELEMENTS),
  localparam int SAMPLE_W    = W * M * N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [TYPE_W-1:0]   wr_type,
  input  logic                in_wr_en,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic [AW:0]         num_elements,
  input  logic                start,
  input  logic                data_request,
  output logic [SAMPLE_W-1:0] training_data,
  output logic [TYPE_W-1:0]   training_data_type,
  output logic [SAMPLE_W-1:0] input_data,
  output logic                read_done,
  output logic [AW-1:0]       sample_index,
  output logic                pass_done,
  output logic                busy,
  output logic                cfg_err
);

  state_e                     state_r;
  logic [AW-1:0]              index_r;
  logic [AW:0]                num_r;
  logic                       pending_r;
  logic                       cfg_err_r;
  logic                       read_done_r;
  logic                       pass_done_r;
  logic [SAMPLE_W-1:0]        training_data_r;
  logic [TYPE_W-1:0]          type_r;
  logic [AW-1:0]              sample_index_r;
  logic [SAMPLE_W-1:0]        input_data_r;

  logic [AW:0]                idx_inc_s;
  logic                       last_s;
  logic                       issue_s;
  logic [AW-1:0]              rd_addr_s;
  logic                       num_ok_s;
  logic [SAMPLE_W+TYPE_W-1:0] ram_q_s;

  assign idx_inc_s = {1'b0, index_r} + {{AW{1'b0}}, 1'b1};
  assign last_s    = (idx_inc_s == num_r);
  assign num_ok_s  = num_in_range(32'(num_elements), 32'(MAX_ELEMENTS));

  // Read issue: from ARMED on a request, or straight out of PRESENT when one is queued.
  always_comb begin
    issue_s   = 1'b0;
    rd_addr_s = index_r;
    case (state_r)
      ST_ARMED: begin
        issue_s   = data_request | pending_r;
        rd_addr_s = index_r;
      end
      ST_PRESENT: begin
        issue_s   = pending_r & ~last_s;
        rd_addr_s = idx_inc_s[AW-1:0];
      end
      default: begin
        issue_s   = 1'b0;
        rd_addr_s = index_r;
      end
    endcase
  end

  knn_sample_ram #(
    .DEPTH (MAX_ELEMENTS),
    .WIDTH (SAMPLE_W + TYPE_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata ({wr_data, wr_type}),
    .re    (issue_s),
    .raddr (rd_addr_s),
    .rdata (ram_q_s)
  );

  // Input-sample holding register, loadable in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      input_data_r <= '0;
    end else if (in_wr_en) begin
      input_data_r <= in_data;
    end else begin
      input_data_r <= input_data_r;
    end
  end

  // Fetch FSM with index counter, one-deep request queue and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= ST_IDLE;
      index_r         <= '0;
      num_r           <= '0;
      pending_r       <= 1'b0;
      cfg_err_r       <= 1'b0;
      read_done_r     <= 1'b0;
      pass_done_r     <= 1'b0;
      training_data_r <= '0;
      type_r          <= '0;
      sample_index_r  <= '0;
    end else if (start) begin
      // start overrides whatever is in flight, so an aborted read never completes
      read_done_r <= 1'b0;
      pass_done_r <= 1'b0;
      pending_r   <= 1'b0;
      index_r     <= '0;
      if (num_ok_s) begin
        state_r   <= ST_ARMED;
        cfg_err_r <= 1'b0;
        num_r     <= num_elements;
      end else begin
        state_r   <= ST_IDLE;
        cfg_err_r <= 1'b1;
      end
    end else begin
      read_done_r <= 1'b0;
      pass_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_ARMED: begin
          if (issue_s) begin
            state_r   <= ST_READ;
            pending_r <= 1'b0;
          end
        end
        ST_READ: begin
          training_data_r <= ram_q_s[SAMPLE_W+TYPE_W-1:TYPE_W];
          type_r          <= ram_q_s[TYPE_W-1:0];
          sample_index_r  <= index_r;
          read_done_r     <= 1'b1;
          pass_done_r     <= last_s;
          pending_r       <= pending_r | data_request;
          state_r         <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (last_s) begin
`ifdef KNN_FEEDER_WRAP_EN
            index_r   <= '0;
            state_r   <= ST_ARMED;
            pending_r <= pending_r | data_request;
`else
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
`endif
          end else begin
            index_r <= idx_inc_s[AW-1:0];
            if (pending_r) begin
              state_r   <= ST_READ;
              pending_r <= 1'b0;
            end else begin
              state_r   <= ST_ARMED;
              pending_r <= data_request;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign training_data      = training_data_r;
  assign training_data_type = type_r;
  assign input_data         = input_data_r;
  assign read_done          = read_done_r;
  assign sample_index       = sample_index_r;
  assign pass_done          = pass_done_r;
  assign busy               = (state_r != ST_IDLE);
  assign cfg_err            = cfg_err_r;

endmodule

// File: tb/tb_knn_training_feeder.sv
// Self-checking bench for knn_training_feeder against a memory-array reference model.
module tb_knn_training_feeder;

  localparam int SW   = 96;
  localparam int TW   = 3;
  localparam int AW   = 5;
  localparam int MAXE = 32;
`ifdef KNN_FEEDER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [SW-1:0] wr_data = '0;
  logic [TW-1:0] wr_type = '0;
  logic          in_wr_en = 1'b0;
  logic [SW-1:0] in_data = '0;
  logic [AW:0]   num_elements = '0;
  logic          start = 1'b0;
  logic          data_request = 1'b0;
  logic [SW-1:0] training_data;
  logic [TW-1:0] training_data_type;
  logic [SW-1:0] input_data;
  logic          read_done;
  logic [AW-1:0] sample_index;
  logic          pass_done;
  logic          busy;
  logic          cfg_err;

  int checks = 0;
  int failures = 0;

  logic [SW-1:0] mem_m [MAXE];
  logic [TW-1:0] type_m [MAXE];
  logic [SW-1:0] in_m;

  typedef struct {
    logic [AW:0] num;
    logic        exp_err;
    logic        exp_busy;
  } cfg_vec_t;
  cfg_vec_t cfg_tab [6];

  knn_training_feeder dut (
    .clk                (clk),
    .rst                (rst),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_type            (wr_type),
    .in_wr_en           (in_wr_en),
    .in_data            (in_data),
    .num_elements       (num_elements),
    .start              (start),
    .data_request       (data_request),
    .training_data      (training_data),
    .training_data_type (training_data_type),
    .input_data         (input_data),
    .read_done          (read_done),
    .sample_index       (sample_index),
    .pass_done          (pass_done),
    .busy               (busy),
    .cfg_err            (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input int a, input logic [SW-1:0] d, input logic [TW-1:0] t);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_type = t;
    tick();
    wr_en = 1'b0;
    mem_m[a] = d; type_m[a] = t;
  endtask

  task automatic load_input(input logic [SW-1:0] d);
    in_wr_en = 1'b1; in_data = d;
    tick();
    in_wr_en = 1'b0;
    in_m = d;
    chk("input_load", 128'(input_data), 128'(in_m));
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num_elements = (AW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  // One isolated request: read_done exactly two edges later, for one cycle.
  task automatic req_expect(input int idx, input bit last, input string tag);
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
    chk({tag, "_early"}, 128'(read_done), 128'(0));
    tick();
    chk({tag, "_rd"}, 128'(read_done), 128'(1));
    chk({tag, "_idx"}, 128'(sample_index), 128'(idx));
    chk({tag, "_data"}, 128'(training_data), 128'(mem_m[idx]));
    chk({tag, "_type"}, 128'(training_data_type), 128'(type_m[idx]));
    chk({tag, "_pass"}, 128'(pass_done), 128'(last));
    chk({tag, "_in"}, 128'(input_data), 128'(in_m));
    tick();
    chk({tag, "_pulse"}, 128'(read_done), 128'(0));
    chk({tag, "_hold"}, 128'(training_data), 128'(mem_m[idx]));
  endtask

  task automatic req_none(input string tag);
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_no_rd"}, 128'(read_done), 128'(0));
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cyc[$];
    int rd_idx[$];
    int rd_pass[$];
    int n;

    cfg_tab[0] = '{num: 6'd0,  exp_err: 1'b1, exp_busy: 1'b0};
    cfg_tab[1] = '{num: 6'd33, exp_err: 1'b1, exp_busy: 1'b0};
    cfg_tab[2] = '{num: 6'd2,  exp_err: 1'b0, exp_busy: 1'b1};
    cfg_tab[3] = '{num: 6'd63, exp_err: 1'b1, exp_busy: 1'b0};
    cfg_tab[4] = '{num: 6'd32, exp_err: 1'b0, exp_busy: 1'b1};
    cfg_tab[5] = '{num: 6'd1,  exp_err: 1'b0, exp_busy: 1'b1};

    // Reset state
    #1;
    chk("rst_data", 128'(training_data), 128'(0));
    chk("rst_type", 128'(training_data_type), 128'(0));
    chk("rst_input", 128'(input_data), 128'(0));
    chk("rst_rd", 128'(read_done), 128'(0));
    chk("rst_idx", 128'(sample_index), 128'(0));
    chk("rst_pass", 128'(pass_done), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cfg", 128'(cfg_err), 128'(0));
    #21 rst = 1'b1;
    tick();

    // Four isolated requests over a four-sample pass
    for (int i = 0; i < 4; i++) write_sample(i, SW'(i + 1), TW'(i));
    load_input(96'h0123_4567_89ab_cdef_fedc_ba98);
    do_start(4);
    chk("t1_busy", 128'(busy), 128'(1));
    for (int i = 0; i < 4; i++) req_expect(i, i == 3, "t1");
    chk("t1_busy_end", 128'(busy), 128'(WRAP));
    if (!WRAP) req_none("t1_fifth");

    // Request held high: one sample every two cycles
    do_start(3);
    data_request = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (read_done) begin
        rd_cyc.push_back(c);
        rd_idx.push_back(int'(sample_index));
        rd_pass.push_back(int'(pass_done));
      end
    end
    data_request = 1'b0;
    chk("t2_count", 128'(rd_cyc.size()), 128'(3));
    for (int k = 0; k < rd_cyc.size() && k < 3; k++) begin
      chk("t2_cycle", 128'(rd_cyc[k]), 128'(2 + 2 * k));
      chk("t2_idx", 128'(rd_idx[k]), 128'(k));
      chk("t2_pass", 128'(rd_pass[k]), 128'(k == 2));
    end
    chk("t2_busy_end", 128'(busy), 128'(WRAP));

    // Range check of num_elements at start
    for (int i = 0; i < 6; i++) begin
      do_start(int'(cfg_tab[i].num));
      chk("t3_cfg_err", 128'(cfg_err), 128'(cfg_tab[i].exp_err));
      chk("t3_busy", 128'(busy), 128'(cfg_tab[i].exp_busy));
    end

    // start during READ of index 2 aborts that read
    do_start(4);
    req_expect(0, 1'b0, "t4a");
    req_expect(1, 1'b0, "t4b");
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
    start = 1'b1; num_elements = 6'd4;
    tick();
    start = 1'b0;
    chk("t4_abort_rd", 128'(read_done), 128'(0));
    tick();
    chk("t4_abort_rd2", 128'(read_done), 128'(0));
    chk("t4_busy", 128'(busy), 128'(1));
    req_expect(0, 1'b0, "t4_after");

    // Write and read of the same address in one cycle returns the old sample
    do_start(4);
    data_request = 1'b1;
    wr_en = 1'b1; wr_addr = '0; wr_data = 96'hdead_beef_0000_1111_2222_3333; wr_type = 3'd7;
    tick();
    data_request = 1'b0; wr_en = 1'b0;
    tick();
    chk("t5_rd", 128'(read_done), 128'(1));
    chk("t5_old_data", 128'(training_data), 128'(mem_m[0]));
    chk("t5_old_type", 128'(training_data_type), 128'(type_m[0]));
    mem_m[0] = 96'hdead_beef_0000_1111_2222_3333;
    type_m[0] = 3'd7;
    tick();
    do_start(4);
    req_expect(0, 1'b0, "t5_new");

    // Asynchronous reset while a sample is presented
    do_start(4);
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
    tick();
    chk("t6_pre_rd", 128'(read_done), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("t6_rd", 128'(read_done), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_data", 128'(training_data), 128'(0));
    chk("t6_type", 128'(training_data_type), 128'(0));
    chk("t6_idx", 128'(sample_index), 128'(0));
    chk("t6_input", 128'(input_data), 128'(0));
    #3 rst = 1'b1;
    tick();
    load_input(in_m);
    do_start(4);
    for (int i = 0; i < 4; i++) req_expect(i, i == 3, "t6_rerun");

    // Pass end with five requests on a two-sample pass
    do_start(2);
    for (int r = 0; r < 5; r++) begin
      if (WRAP || r < 2) req_expect(r % 2, (r % 2) == 1, "t7");
      else req_none("t7_idle");
    end

    // Randomized passes against the memory model
    for (int round = 0; round < 3; round++) begin
      for (int a = 0; a < MAXE; a++)
        write_sample(a, {$urandom, $urandom, $urandom}, TW'($urandom));
      load_input({$urandom, $urandom, $urandom});
      n = int'($urandom_range(1, MAXE));
      do_start(n);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        req_expect(k, k == n - 1, "rnd");
      end
      chk("rnd_busy_end", 128'(busy), 128'(WRAP));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
